// File: rtl/multi_rundown_counter.sv
// Multi-channel loadable rundown timers (watchdog / drag-out source); expiry pulse N+1 enabled cycles after Start.
// No backpressure: clk_en freezes every channel and requests arriving while it is low are dropped, not queued.
// MULTI_RUNDOWN_FINISH_EN: simulation-only report and $finish on expiry; undefined builds are pure RTL.
module multi_rundown_counter #(
  parameter int CHANNELS       = 4,
  parameter int COUNT_BITWIDTH = 16,
  parameter int DEFAULT_WAIT   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic [CHANNELS-1:0]                Start,
  input  logic [CHANNELS-1:0]                Cancel,
  input  logic [COUNT_BITWIDTH-1:0]          LoadValue,
  input  logic                               UseDefault,
  input  logic [CHANNELS-1:0]                ClearSticky,
  output logic [CHANNELS-1:0]                Active,
  output logic [CHANNELS-1:0]                ExpiredPulse,
  output logic [CHANNELS-1:0]                ExpiredSticky,
  output logic                               AnyActive,
  output logic [CHANNELS*COUNT_BITWIDTH-1:0] CountOut
);

  localparam logic [COUNT_BITWIDTH-1:0] DEFAULT_LOAD = COUNT_BITWIDTH'(DEFAULT_WAIT);

  logic [COUNT_BITWIDTH-1:0] count [CHANNELS];
  logic [COUNT_BITWIDTH-1:0] load_value;

  assign load_value = (UseDefault && (LoadValue == '0)) ? DEFAULT_LOAD : LoadValue;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Active        <= '0;
      ExpiredPulse  <= '0;
      ExpiredSticky <= '0;
      for (int i = 0; i < CHANNELS; i++) count[i] <= '0;
    end else begin
      // The pulse is cleared on every edge, enabled or not, so it is never stretched.
      ExpiredPulse <= '0;
      if (clk_en) begin
        for (int i = 0; i < CHANNELS; i++) begin
          // Clear first so a same-cycle expiry below overrides it.
          if (ClearSticky[i]) ExpiredSticky[i] <= 1'b0;
          if (Cancel[i]) begin
            Active[i] <= 1'b0;
          end else if (Start[i]) begin
            count[i]  <= load_value;
            Active[i] <= 1'b1;
          end else if (Active[i]) begin
            if (count[i] == '0) begin
              Active[i]        <= 1'b0;
              ExpiredPulse[i]  <= 1'b1;
              ExpiredSticky[i] <= 1'b1;
            end else begin
              count[i] <= count[i] - 1'b1;
            end
          end
        end
      end
    end
  end

  assign AnyActive = |Active;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count_out
    assign CountOut[g*COUNT_BITWIDTH +: COUNT_BITWIDTH] = count[g];
  end

`ifdef MULTI_RUNDOWN_FINISH_EN
  int unsigned elapsed [CHANNELS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) elapsed[i] <= 0;
    end else if (clk_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (Start[i] && !Cancel[i]) elapsed[i] <= 0;
        else if (Active[i])         elapsed[i] <= elapsed[i] + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && (|ExpiredPulse)) begin
      for (int i = 0; i < CHANNELS; i++)
        if (ExpiredPulse[i])
          $display("><>< RUNDOWN CHANNEL %0d ELAPSED AFTER %0d CYCLES ><><", i, elapsed[i]);
      $finish;
    end
  end
`else
  // Expiry is visible only through ExpiredPulse / ExpiredSticky.
`endif

endmodule

// File: tb/tb_multi_rundown_counter.sv
// Directed bench for multi_rundown_counter with hand-computed expectations.
module tb_multi_rundown_counter;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic [CH-1:0] Start = '0;
  logic [CH-1:0] Cancel = '0;
  logic [W-1:0]  LoadValue = '0;
  logic          UseDefault = 1'b0;
  logic [CH-1:0] ClearSticky = '0;
  logic [CH-1:0] Active;
  logic [CH-1:0] ExpiredPulse;
  logic [CH-1:0] ExpiredSticky;
  logic          AnyActive;
  logic [CH*W-1:0] CountOut;

  int n_cmp = 0;
  int n_err = 0;

  multi_rundown_counter #(.CHANNELS(CH), .COUNT_BITWIDTH(W), .DEFAULT_WAIT(8)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .Start(Start), .Cancel(Cancel),
    .LoadValue(LoadValue), .UseDefault(UseDefault), .ClearSticky(ClearSticky),
    .Active(Active), .ExpiredPulse(ExpiredPulse), .ExpiredSticky(ExpiredSticky),
    .AnyActive(AnyActive), .CountOut(CountOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cnt_of(input int ch);
    return CountOut[ch*W +: W];
  endfunction

  // Counts enabled ticks after the Start edge until the channel pulses (bounded).
  task automatic wait_pulse(input int ch, input int exp_cycles, input string tag);
    int k;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (ExpiredPulse[ch]) break;
    end
    check(tag, k, exp_cycles);
    tick();
    check({tag, "_width"}, ExpiredPulse[ch], 1'b0);
  endtask

  initial begin
    logic seen;

    // Reset state
    #1;
    check("rst_active", Active, 4'b0000);
    check("rst_count", CountOut, 64'h0);
    check("rst_sticky", ExpiredSticky, 4'b0000);
    tick();
    rst = 1'b0;
    clk_en = 1'b1;

    // Basic expiry: ch0 load 3
    Start = 4'b0001; LoadValue = 16'd3;
    tick();
    Start = '0;
    check("basic_load", cnt_of(0), 16'd3);
    check("basic_active", Active[0], 1'b1);
    for (int k = 2; k >= 0; k--) begin
      tick();
      check("basic_cnt", cnt_of(0), 16'(k));
      check("basic_nopulse", ExpiredPulse[0], 1'b0);
    end
    tick();
    check("basic_pulse", ExpiredPulse, 4'b0001);
    check("basic_sticky", ExpiredSticky[0], 1'b1);
    check("basic_inactive", Active[0], 1'b0);
    tick();
    check("basic_pulse_clr", ExpiredPulse[0], 1'b0);
    check("basic_cnt_hold", cnt_of(0), 16'd0);

    // Default and zero loads
    Start = 4'b0001; LoadValue = 16'd0; UseDefault = 1'b1;
    tick();
    Start = '0; UseDefault = 1'b0;
    check("dflt_load", cnt_of(0), 16'd8);
    wait_pulse(0, 9, "dflt_lat");
    Start = 4'b0001; LoadValue = 16'd0;
    tick();
    Start = '0;
    check("zero_active", Active[0], 1'b1);
    wait_pulse(0, 1, "zero_lat");

    // Reset mid-count
    Start = 4'b0010; LoadValue = 16'd10;
    tick();
    Start = '0;
    tick();
    tick();
    check("pre_rst_cnt", cnt_of(1), 16'd8);
    #2 rst = 1'b1;
    #1;
    check("midrst_active", Active, 4'b0000);
    check("midrst_count", CountOut, 64'h0);
    check("midrst_sticky", ExpiredSticky, 4'b0000);
    check("midrst_any", AnyActive, 1'b0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      seen |= |ExpiredPulse;
    end
    check("postrst_nopulse", seen, 1'b0);

    // Restart ch1
    Start = 4'b0010; LoadValue = 16'd5;
    tick();
    Start = '0;
    tick(); tick(); tick();
    check("restart_pre", cnt_of(1), 16'd2);
    Start = 4'b0010;
    tick();
    Start = '0;
    check("restart_reload", cnt_of(1), 16'd5);
    wait_pulse(1, 6, "restart_lat");
    check("restart_sticky", ExpiredSticky[1], 1'b1);

    // Cancel ch2 at count 2
    Start = 4'b0100; LoadValue = 16'd5;
    tick();
    Start = '0;
    tick(); tick(); tick();
    Cancel = 4'b0100;
    tick();
    Cancel = '0;
    check("cancel_active", Active[2], 1'b0);
    check("cancel_cnt", cnt_of(2), 16'd2);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen |= ExpiredPulse[2];
    end
    check("cancel_nopulse", seen, 1'b0);
    check("cancel_sticky", ExpiredSticky[2], 1'b0);
    check("cancel_cnt_hold", cnt_of(2), 16'd2);

    // Start + Cancel same cycle: Cancel wins
    Start = 4'b0100; Cancel = 4'b0100; LoadValue = 16'd7;
    tick();
    Start = '0; Cancel = '0;
    check("startcancel_active", Active[2], 1'b0);
    check("startcancel_cnt", cnt_of(2), 16'd2);

    // clk_en gating: ch2 load 2, three disabled cycles
    Start = 4'b0100; LoadValue = 16'd2;
    tick();
    Start = '0;
    tick();
    check("gate_cnt1", cnt_of(2), 16'd1);
    clk_en = 1'b0;
    Start = 4'b1000; LoadValue = 16'd9;
    tick();
    Start = '0;
    tick(); tick();
    check("gate_frozen", cnt_of(2), 16'd1);
    check("gate_start_ignored", Active[3], 1'b0);
    clk_en = 1'b1;
    tick();
    check("gate_cnt0", cnt_of(2), 16'd0);
    check("gate_nopulse_early", ExpiredPulse[2], 1'b0);
    tick();
    check("gate_pulse", ExpiredPulse, 4'b0100);
    clk_en = 1'b0;
    tick();
    check("gate_pulse_width", ExpiredPulse[2], 1'b0);
    check("gate_start_not_queued", Active[3], 1'b0);
    clk_en = 1'b1;

    // Multi-channel simultaneous expiry
    Start = 4'b1001; LoadValue = 16'd1;
    tick();
    Start = '0;
    check("multi_any_on", AnyActive, 1'b1);
    tick();
    check("multi_cnt0", cnt_of(0), 16'd0);
    check("multi_cnt3", cnt_of(3), 16'd0);
    tick();
    check("multi_pulse", ExpiredPulse, 4'b1001);
    check("multi_any_off", AnyActive, 1'b0);

    // ClearSticky coincident with expiry: expiry wins
    Start = 4'b1000; LoadValue = 16'd0;
    tick();
    Start = '0;
    ClearSticky = 4'b1000;
    tick();
    ClearSticky = '0;
    check("clr_vs_expiry_pulse", ExpiredPulse[3], 1'b1);
    check("clr_vs_expiry_sticky", ExpiredSticky[3], 1'b1);
    ClearSticky = 4'b1000;
    tick();
    ClearSticky = '0;
    check("clr_sticky", ExpiredSticky, 4'b0111);
    clk_en = 1'b0;
    ClearSticky = 4'b0010;
    tick();
    ClearSticky = '0;
    check("clr_gated", ExpiredSticky[1], 1'b1);
    clk_en = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_rundown_counter.md
# multi_rundown_counter

Parametrised, multi-channel successor to the single-channel rundown counter used by our benches and debug logic. Provides CHANNELS independent loadable down-counters, each started, restarted or cancelled at run time, reporting a one-cycle expiry pulse, a sticky expiry flag and the live count. Sits beside the CPU top level as a watchdog and drag-out timer source. It is synthesisable; the simulation stop is a compile-time option.

## Interface
- CHANNELS, 4, number of independent counter channels (≥1)
- COUNT_BITWIDTH, 16, width of each channel's count register
- DEFAULT_WAIT, 8, value loaded when Start is asserted with LoadValue == 0 and UseDefault = 1

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high; clears all state immediately
- clk_en  in  1  global advance enable; Start/Cancel/ClearSticky/decrement act only when high
- Start  in  CHANNELS  per-channel start/restart request
- Cancel  in  CHANNELS  per-channel stop without expiry
- LoadValue  in  COUNT_BITWIDTH  count loaded on Start (shared by all channels)
- UseDefault  in  1  when 1 and LoadValue == 0, load DEFAULT_WAIT instead
- ClearSticky  in  CHANNELS  clears ExpiredSticky bit
- Active  out  CHANNELS  channel is counting
- ExpiredPulse  out  CHANNELS  one-clk pulse on expiry
- ExpiredSticky  out  CHANNELS  latched expiry status
- AnyActive  out  1  OR of Active
- CountOut  out  CHANNELS*COUNT_BITWIDTH  channel i count at bits [i*COUNT_BITWIDTH +: COUNT_BITWIDTH]

## Operation
- Per-channel state: Count, Active, ExpiredPulse, ExpiredSticky. All reset to 0.
- Priority per channel when clk_en = 1: Cancel > Start > expiry check > decrement.
  - Cancel: Active <= 0; Count held; no pulse, sticky unchanged.
  - Start (no Cancel): Count <= load value; Active <= 1; restarts an already-active channel; no pulse even if old Count was 0.
  - Active, Count == 0: Active <= 0, ExpiredPulse <= 1, ExpiredSticky <= 1.
  - Active, Count != 0: Count <= Count - 1.
  - Inactive, no request: hold.
- Load value: UseDefault && LoadValue == 0 ? DEFAULT_WAIT (truncated to COUNT_BITWIDTH) : LoadValue. LoadValue == 0 with UseDefault = 0 expires on the next enabled cycle.
- Decrement never wraps: decrement only occurs when Count != 0.
- ExpiredPulse clears on the next clk edge regardless of clk_en (one clk wide, never stretched).
- ClearSticky with clk_en: clears ExpiredSticky; a same-cycle expiry wins (bit stays 1).
- clk_en = 0: Count, Active, ExpiredSticky frozen; requests ignored (not queued).
- rst mid-count: all channels inactive, counts 0, no pulse generated.

## Timing
- Start sampled at edge E with load value N, clk_en held high: Count = N after E, reaches 0 after E+N, ExpiredPulse high and Active low after E+N+1. Expiry latency = N+1 enabled cycles.
- Each disabled cycle adds one cycle to that latency.
- All outputs are registered except AnyActive (OR of registered Active) and CountOut (direct register view).
- Channels are fully independent; simultaneous expiry on several channels pulses all of them in the same cycle.

## Configuration
- MULTI_RUNDOWN_FINISH_EN defined: on any ExpiredPulse rising, simulation prints "><>< RUNDOWN CHANNEL <i> ELAPSED AFTER <N> CYCLES ><><" for every expiring channel in that cycle, then calls $finish after the edge on which the pulse is observed. The code is excluded from synthesis.
- Undefined: no $display/$finish; the block is pure RTL and expiry is reported only through ExpiredPulse/ExpiredSticky.

## Test plan
- Reset: rst pulse mid-run -> all outputs 0 immediately, CountOut = 0, no ExpiredPulse afterwards.
- Basic expiry: ch0 Start, LoadValue = 3, clk_en = 1 -> CountOut[0] 3,2,1,0; ExpiredPulse[0] high exactly 4 cycles after Start edge for 1 cycle; Sticky[0] = 1; Active[0] = 0.
- Default and zero: Start with LoadValue = 0, UseDefault = 1 -> expiry after 9 cycles; with UseDefault = 0 -> expiry after 1 cycle.
- Restart/cancel: ch1 load 5, Start again at Count = 2 -> reloads 5, expiry 6 cycles after the second Start; ch2 Cancel at Count = 2 -> Active 0, Count holds 2, no pulse, Sticky 0; Start+Cancel same cycle -> Cancel wins.
- clk_en gating: load 2, clk_en low for 3 cycles mid-count -> expiry delayed by 3 cycles, pulse still 1 clk wide; Start during clk_en = 0 ignored.
- Sticky and multi-channel: ch0 and ch3 load 1 same cycle -> both pulse together, AnyActive falls same cycle; ClearSticky[3] coincident with a new ch3 expiry -> Sticky[3] stays 1.
